// File: rtl/shift_tx_if.sv
// rtl/shift_tx_if.sv - load handshake and serial output bundle for shift_tx
interface shift_tx_if #(
  parameter int WIDTH = 8
) ();
  logic             enable;
  logic [WIDTH-1:0] d;
  logic             dir;
  logic             load_valid;
  logic             load_ready;
  logic             s_out;
  logic             bit_stb;
  logic [1:0]       s_ctrl;
  logic             busy;
  logic             done;

  modport master (
    output enable, d, dir, load_valid,
    input  load_ready, s_out, bit_stb, s_ctrl, busy, done
  );

  modport slave (
    input  enable, d, dir, load_valid,
    output load_ready, s_out, bit_stb, s_ctrl, busy, done
  );
endinterface

// File: rtl/shift_tx.sv
// rtl/shift_tx.sv - parallel-in serial-out frame transmitter with per-bit strobe/shift command
// Optional even-parity bit after the data word when SHIFT_TX_PARITY_EN is defined.
module shift_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input logic     clk,
  input logic     rst,
  shift_tx_if.slave tx
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, FIN = 2'd3} state_t;
  logic par_q;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FIN = 2'd3} state_t;
`endif

  state_t           state, next_state;
  logic [WIDTH-1:0] shreg;
  logic             dir_q;
  logic [CW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             stb_q, done_q, s_out_q, stb_next;
  logic             tick, data_end, out_bit;
  logic [WIDTH-1:0] shifted;

  assign tick     = (div_cnt == DW'(DIV - 1));
  // The strobe of the last data bit has been shown once bit_cnt has reached WIDTH.
  assign data_end = stb_q && (bit_cnt == CW'(WIDTH));
  assign out_bit  = dir_q ? shreg[0] : shreg[WIDTH-1];
  assign shifted  = dir_q ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else if (tx.enable)
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (tx.load_valid) next_state = SHIFT;
`ifdef SHIFT_TX_PARITY_EN
      SHIFT: if (data_end) next_state = PAR;
      PAR:   if (stb_q) next_state = FIN;
`else
      SHIFT: if (data_end) next_state = FIN;
`endif
      FIN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stb_next      = 1'b0;
    tx.load_ready = (state == IDLE);
    tx.busy       = (state != IDLE);
    tx.bit_stb    = stb_q & tx.enable;
    tx.done       = done_q & tx.enable;
    tx.s_out      = s_out_q;
    tx.s_ctrl     = 2'b00;
    if (tx.bit_stb)
      tx.s_ctrl = {dir_q, 1'b1};
    case (state)
`ifdef SHIFT_TX_PARITY_EN
      SHIFT: stb_next = tick;
      PAR:   stb_next = tick && !stb_q;
`else
      SHIFT: stb_next = tick && !data_end;
`endif
      default: stb_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      dir_q   <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      s_out_q <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (tx.enable) begin
      stb_q  <= stb_next;
      done_q <= (next_state == FIN) && (state != FIN);
      case (state)
        IDLE: if (tx.load_valid) begin
          shreg   <= tx.d;
          dir_q   <= tx.dir;
          bit_cnt <= '0;
          div_cnt <= '0;
          s_out_q <= tx.dir ? tx.d[0] : tx.d[WIDTH-1];
`ifdef SHIFT_TX_PARITY_EN
          par_q   <= ^tx.d;
`endif
        end
        SHIFT: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick && !data_end) begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt + 1'b1;
          end
`ifdef SHIFT_TX_PARITY_EN
          s_out_q <= data_end ? par_q : out_bit;
`else
          s_out_q <= out_bit;
`endif
        end
`ifdef SHIFT_TX_PARITY_EN
        PAR: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          s_out_q <= par_q;
        end
`endif
        FIN: s_out_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
